// File: rtl/bist_seq_ctrl.sv
// BIST sequencer: runs M_ROUND rounds of N_PAT pattern-step cycles, each round closed by a
// one-cycle gap, then compares the MISR signature against GOLDEN. Supports abort.
module bist_seq_ctrl #(
    parameter int               N_PAT   = 9,
    parameter int               M_ROUND = 9,
    parameter int               CNT_W   = 4,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] GOLDEN  = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic             ABORT,
    input  logic [SIG_W-1:0] SIG_IN,
    output logic             INIT,
    output logic             RUNNING,
    output logic             OUT,
    output logic             ROUND_DONE,
    output logic             FINISH,
    output logic             BIST_END,
    output logic             PASS,
    output logic             ABORTED,
    output logic [CNT_W-1:0] PAT_IDX,
    output logic [CNT_W-1:0] ROUND_IDX
);

    localparam logic [CNT_W-1:0] PAT_LAST = CNT_W'(N_PAT - 1);
    localparam logic [CNT_W-1:0] RND_LAST = CNT_W'(M_ROUND - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_INIT = 3'd2,
        S_RUN  = 3'd3,
        S_GAP  = 3'd4,
        S_FIN  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t state;
    logic   abort_hit;

    assign abort_hit = ABORT && (state == S_INIT || state == S_RUN || state == S_GAP);

    // Outputs are registered alongside the state they belong to, so each one is a pure
    // function of the current state with no input-to-output path.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state      <= S_IDLE;
            INIT       <= 1'b0;
            RUNNING    <= 1'b0;
            OUT        <= 1'b0;
            ROUND_DONE <= 1'b0;
            FINISH     <= 1'b0;
            BIST_END   <= 1'b0;
            PASS       <= 1'b0;
            ABORTED    <= 1'b0;
            PAT_IDX    <= '0;
            ROUND_IDX  <= '0;
        end else begin
            INIT       <= 1'b0;
            RUNNING    <= 1'b0;
            OUT        <= 1'b0;
            ROUND_DONE <= 1'b0;
            FINISH     <= 1'b0;
            BIST_END   <= 1'b0;
            if (abort_hit) begin
                state     <= S_DONE;
                BIST_END  <= 1'b1;
                ABORTED   <= 1'b1;
                PASS      <= 1'b0;
                PAT_IDX   <= '0;
                ROUND_IDX <= '0;
            end else begin
                case (state)
                    // START must be seen low first so a pin held high through reset cannot launch a run
                    S_IDLE: begin
                        if (!START) state <= S_ARM;
                    end
                    S_ARM: begin
                        if (START) begin
                            state     <= S_INIT;
                            INIT      <= 1'b1;
                            PASS      <= 1'b0;
                            ABORTED   <= 1'b0;
                            PAT_IDX   <= '0;
                            ROUND_IDX <= '0;
                        end
                    end
                    S_INIT: begin
                        state   <= S_RUN;
                        RUNNING <= 1'b1;
                        OUT     <= 1'b1;
                    end
                    S_RUN: begin
                        RUNNING <= 1'b1;
                        if (PAT_IDX == PAT_LAST) begin
                            state      <= S_GAP;
                            PAT_IDX    <= '0;
                            ROUND_DONE <= 1'b1;
                        end else begin
                            PAT_IDX <= PAT_IDX + 1'b1;
                            OUT     <= 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (ROUND_IDX == RND_LAST) begin
                            state     <= S_FIN;
                            ROUND_IDX <= '0;
                            FINISH    <= 1'b1;
                        end else begin
                            state     <= S_RUN;
                            ROUND_IDX <= ROUND_IDX + 1'b1;
                            RUNNING   <= 1'b1;
                            OUT       <= 1'b1;
                        end
                    end
                    S_FIN: begin
                        state    <= S_DONE;
                        BIST_END <= 1'b1;
                        PASS     <= (SIG_IN == GOLDEN);
                    end
                    S_DONE: begin
                        if (!START) state <= S_ARM;
                        else        BIST_END <= 1'b1;
                    end
                    default: begin
                        state     <= S_IDLE;
                        PASS      <= 1'b0;
                        ABORTED   <= 1'b0;
                        PAT_IDX   <= '0;
                        ROUND_IDX <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Scoreboard bench for bist_seq_ctrl: a default instance and a minimum (1x1) instance,
// per-cycle expected output vectors are queued at stimulus time and popped each cycle.
module tb_bist_seq_ctrl;

    typedef struct packed {
        logic       init;
        logic       running;
        logic       out;
        logic       rd;
        logic       fin;
        logic       bend;
        logic       pass;
        logic       aborted;
        logic [3:0] pat;
        logic [3:0] rnd;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b1;
    logic        abort = 1'b0;
    logic        start_m = 1'b0;
    logic        abort_m = 1'b0;
    logic [15:0] sig = 16'h0000;

    logic       init_d, running_d, out_d, rd_d, fin_d, bend_d, pass_d, ab_d;
    logic [3:0] pat_d, rnd_d;
    logic       init_m, running_m, out_m, rd_m, fin_m, bend_m, pass_m, ab_m;
    logic [3:0] pat_m, rnd_m;
    obs_t       obs_d, obs_m, e_d, e_m;

    obs_t q_d[$];
    obs_t q_m[$];
    int   n_chk = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   n_rd  = 0;
    int   plan_c, plan_cut;

    always #5 clk = ~clk;

    bist_seq_ctrl u_dut (
        .CLK(clk), .RESET_N(rst_n), .START(start), .ABORT(abort), .SIG_IN(sig),
        .INIT(init_d), .RUNNING(running_d), .OUT(out_d), .ROUND_DONE(rd_d), .FINISH(fin_d),
        .BIST_END(bend_d), .PASS(pass_d), .ABORTED(ab_d), .PAT_IDX(pat_d), .ROUND_IDX(rnd_d)
    );

    bist_seq_ctrl #(.N_PAT(1), .M_ROUND(1)) u_min (
        .CLK(clk), .RESET_N(rst_n), .START(start_m), .ABORT(abort_m), .SIG_IN(sig),
        .INIT(init_m), .RUNNING(running_m), .OUT(out_m), .ROUND_DONE(rd_m), .FINISH(fin_m),
        .BIST_END(bend_m), .PASS(pass_m), .ABORTED(ab_m), .PAT_IDX(pat_m), .ROUND_IDX(rnd_m)
    );

    assign obs_d = {init_d, running_d, out_d, rd_d, fin_d, bend_d, pass_d, ab_d, pat_d, rnd_d};
    assign obs_m = {init_m, running_m, out_m, rd_m, fin_m, bend_m, pass_m, ab_m, pat_m, rnd_m};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (q_d.size() > 0) begin
            e_d = q_d.pop_front();
            check("trace_dut", 32'(obs_d), 32'(e_d));
        end
        if (q_m.size() > 0) begin
            e_m = q_m.pop_front();
            check("trace_min", 32'(obs_m), 32'(e_m));
        end
        if (out_d) n_out++;
        if (rd_d)  n_rd++;
    end

    task automatic exp_push(input bit m, input obs_t o);
        if (m) q_m.push_back(o);
        else   q_d.push_back(o);
    endtask

    task automatic emit(input bit m, input obs_t o);
        if (plan_cut < 0 || plan_c <= plan_cut) exp_push(m, o);
        plan_c++;
    endtask

    // Expected trace from INIT onward; cut >= 0 truncates after that cycle (abort / reset).
    task automatic plan_run(input bit m, input int n, input int r, input bit sigok,
                            input int cut, input int done_cyc);
        obs_t o;
        plan_c   = 0;
        plan_cut = cut;
        o = '0; o.init = 1'b1; emit(m, o);
        for (int ri = 0; ri < r; ri++) begin
            for (int pi = 0; pi < n; pi++) begin
                o = '0; o.running = 1'b1; o.out = 1'b1; o.pat = 4'(pi); o.rnd = 4'(ri);
                emit(m, o);
            end
            o = '0; o.running = 1'b1; o.rd = 1'b1; o.rnd = 4'(ri); emit(m, o);
        end
        o = '0; o.fin = 1'b1; emit(m, o);
        for (int i = 0; i < done_cyc; i++) begin
            o = '0; o.bend = 1'b1;
            if (cut >= 0) o.aborted = 1'b1;
            else          o.pass = sigok;
            exp_push(m, o);
        end
    endtask

    task automatic start_run(input bit m);
        @(negedge clk);
        if (m) start_m = 1'b0; else start = 1'b0;
        repeat (2) @(negedge clk);
        if (m) start_m = 1'b1; else start = 1'b1;
    endtask

    task automatic drain();
        int i = 0;
        while ((q_d.size() > 0 || q_m.size() > 0) && i < 400) begin
            @(negedge clk);
            i++;
        end
        check("drain_bound", 32'(i < 400), 32'd1);
    endtask

    task automatic reset_checks(input string tag);
        #1;
        check({tag, "_async"}, 32'({obs_d, obs_m}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check({tag, "_idle"}, 32'({obs_d, obs_m}), 32'd0);
        end
    endtask

    initial begin
        // power-on reset with START held high
        #2 rst_n = 1'b0;
        reset_checks("rst0");

        // default full run, matching signature
        n_out = 0; n_rd = 0;
        start_run(1'b0);
        plan_run(1'b0, 9, 9, 1'b1, -1, 10);
        drain();
        check("out_cycles", 32'(n_out), 32'd81);
        check("rd_pulses", 32'(n_rd), 32'd9);

        // signature mismatch
        sig = 16'h0001;
        start_run(1'b0);
        plan_run(1'b0, 9, 9, 1'b0, -1, 4);
        drain();
        sig = 16'h0000;

        // abort at ROUND_IDX=2, PAT_IDX=5 (cycle 26 after INIT)
        start_run(1'b0);
        plan_run(1'b0, 9, 9, 1'b1, 26, 5);
        repeat (27) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain();

        // restart from DONE recomputes PASS and ABORTED
        start_run(1'b0);
        plan_run(1'b0, 9, 9, 1'b1, -1, 3);
        drain();

        // abort coinciding with the last GAP cycle wins over FIN
        start_run(1'b0);
        plan_run(1'b0, 9, 9, 1'b1, 90, 4);
        repeat (91) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        drain();

        // reset mid-run at PAT_IDX=4, ROUND_IDX=3 (cycle 35)
        start_run(1'b0);
        plan_run(1'b0, 9, 9, 1'b1, 35, 0);
        repeat (36) @(negedge clk);
        rst_n = 1'b0;
        reset_checks("rst_mid");
        drain();

        // minimum instance: INIT, RUN, GAP, FIN, DONE
        start_run(1'b1);
        plan_run(1'b1, 1, 1, 1'b1, -1, 3);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
